pc_redirect_unit: RTL and testbench
===================================

PC_REDIRECT_UNIT -- requirements
Module: pc_redirect_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter FLUSH_CYCLES, default 2, range 1..7, cycles flush stays high after a redirect.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 stall  in  1  pipeline hold; freezes sequential PC advance and the flush counter.
REQ-006 br_valid  in  1  a branch is in the evaluate stage this cycle.
REQ-007 bcres  in  1  branch-condition result from the upstream condition evaluator; meaningful only with br_valid.
REQ-008 br_pc  in  32  byte address of the branch instruction.
REQ-009 br_offset  in  32  sign-extended word offset of the branch.
REQ-010 jump_valid  in  1  unconditional jump request.
REQ-011 jump_target  in  32  jump byte address.
REQ-012 pc  out  32  current fetch address, registered.
REQ-013 redirect  out  1  one-cycle pulse, high in the cycle pc first shows a redirect target.
REQ-014 flush  out  1  squash wrong-path instructions upstream, registered.
REQ-015 taken_cnt  out  16  taken-branch count (see Configuration).
REQ-016 nottaken_cnt  out  16  not-taken-branch count (see Configuration).

Function
REQ-017 States: RUN, FLUSH; FSM, pc, counters all registered.
REQ-018 Taken branch = br_valid & bcres in RUN; target = br_pc + 4 + (br_offset << 2), modulo 2^32 (wrap, no overflow flag).
REQ-019 Jump = jump_valid in RUN with no taken branch that cycle; target = {jump_target[31:2], 2'b00}.
REQ-020 Simultaneous taken branch and jump: branch wins, jump is dropped.
REQ-021 Redirect (taken branch or jump): next edge pc <= target, redirect <= 1, flush <= 1, state -> FLUSH, flush counter <= FLUSH_CYCLES-1; applies even when stall=1.
REQ-022 RUN, no redirect: pc <= pc+4 (wrap at 2^32) if stall=0, else pc holds; br_valid & !bcres has no effect on pc.
REQ-023 redirect returns to 0 one cycle after it rises regardless of stall.
REQ-024 FLUSH: br_valid, bcres, jump_valid ignored (wrong path); pc advances +4 when stall=0.
REQ-025 FLUSH: counter decrements only when stall=0; when counter=0 and stall=0, state -> RUN and flush <= 0 on that edge.
REQ-026 Result: flush high for exactly FLUSH_CYCLES unstalled cycles, extended by every stalled cycle.
REQ-027 Redirect latency: one edge from request to new pc; first instruction at target fetched in the redirect cycle.

Reset
REQ-028 rst=1 asynchronously forces pc=RESET_PC, state=RUN, redirect=0, flush=0, flush counter=0, taken_cnt=0, nottaken_cnt=0.
REQ-029 Reset during FLUSH aborts the flush immediately; first edge after rst release performs normal RUN behaviour.

Configuration
REQ-030 Macro BRANCH_STATS_EN defined: taken_cnt increments on each taken branch accepted in RUN, nottaken_cnt on each br_valid & !bcres in RUN; both saturate at 16'hFFFF; branches ignored in FLUSH not counted.
REQ-031 Macro BRANCH_STATS_EN undefined: no counter registers; taken_cnt and nottaken_cnt ports present, tied to 0.

Verification
REQ-032 Reset release, stall=0, 3 cycles -> pc 0x0, 0x4, 0x8, 0xC; flush=0, redirect=0.
REQ-033 RUN, br_valid=1, bcres=1, br_pc=0x100, br_offset=0xFFFF_FFFC -> next pc=0xF4, redirect 1 cycle, flush high 2 cycles, then pc 0xF8, 0xFC with flush=0 on the 0xFC cycle.
REQ-034 Same cycle br_valid=1, bcres=1 (target 0x200) and jump_valid=1, jump_target=0x403 -> pc=0x200; during following FLUSH a jump to 0x400 is ignored.
REQ-035 Taken branch, stall=1 held 3 cycles in FLUSH -> pc jumps to target, holds; flush stays high 3+2 cycles; redirect still exactly 1 cycle.
REQ-036 br_pc=0xFFFF_FFF8, br_offset=1 -> pc=0x0000_0000 (wrap); then rst mid-FLUSH -> pc=RESET_PC, flush=0 immediately.
REQ-037 BRANCH_STATS_EN defined: 3 taken (non-overlapping) + 2 not-taken in RUN, 1 branch during FLUSH -> taken_cnt=3, nottaken_cnt=2; undefined -> both 0.

Source files
------------

// File: rtl/pc_redirect_unit.sv
// Fetch PC generator with branch/jump redirect and a wrong-path flush window.
// Define BRANCH_STATS_EN to build the saturating taken/not-taken branch counters.
module pc_redirect_unit #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        br_valid,
    input  logic        bcres,
    input  logic [31:0] br_pc,
    input  logic [31:0] br_offset,
    input  logic        jump_valid,
    input  logic [31:0] jump_target,
    output logic [31:0] pc,
    output logic        redirect,
    output logic        flush,
    output logic [15:0] taken_cnt,
    output logic [15:0] nottaken_cnt
);

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    localparam logic [2:0] FCNT_INIT = 3'(FLUSH_CYCLES - 1);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        redirect_q, redirect_d;
    logic        flush_q, flush_d;
    logic [2:0]  fcnt_q, fcnt_d;

    logic        take_br;
    logic        take_jmp;
    logic [31:0] br_target;
    logic [31:0] jmp_target;
    logic [31:0] pc_seq;
    logic        unused_jt_lsbs;

    // Branch beats jump; both are only honoured on the correct path (RUN).
    assign take_br    = (state_q == RUN) && br_valid && bcres;
    assign take_jmp   = (state_q == RUN) && jump_valid && !take_br;
    assign br_target  = br_pc + 32'd4 + (br_offset << 2);
    assign jmp_target = {jump_target[31:2], 2'b00};
    assign pc_seq     = pc_q + 32'd4;
    assign unused_jt_lsbs = ^jump_target[1:0];

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        redirect_d = 1'b0;
        flush_d    = flush_q;
        fcnt_d     = fcnt_q;
        case (state_q)
            RUN: begin
                // A redirect is taken even while stalled so the target is never lost.
                if (take_br || take_jmp) begin
                    pc_d       = take_br ? br_target : jmp_target;
                    redirect_d = 1'b1;
                    flush_d    = 1'b1;
                    fcnt_d     = FCNT_INIT;
                    state_d    = FLUSH;
                end else if (!stall) begin
                    pc_d = pc_seq;
                end
            end
            FLUSH: begin
                if (!stall) begin
                    pc_d = pc_seq;
                    if (fcnt_q == 3'd0) begin
                        state_d = RUN;
                        flush_d = 1'b0;
                    end else begin
                        fcnt_d = fcnt_q - 3'd1;
                    end
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RUN;
            pc_q       <= RESET_PC;
            redirect_q <= 1'b0;
            flush_q    <= 1'b0;
            fcnt_q     <= 3'd0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            redirect_q <= redirect_d;
            flush_q    <= flush_d;
            fcnt_q     <= fcnt_d;
        end
    end

    assign pc       = pc_q;
    assign redirect = redirect_q;
    assign flush    = flush_q;

`ifdef BRANCH_STATS_EN
    logic [15:0] taken_q;
    logic [15:0] nottaken_q;
    logic        count_nt;

    assign count_nt = (state_q == RUN) && br_valid && !bcres;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            taken_q    <= 16'd0;
            nottaken_q <= 16'd0;
        end else begin
            if (take_br && (taken_q != 16'hFFFF))
                taken_q <= taken_q + 16'd1;
            if (count_nt && (nottaken_q != 16'hFFFF))
                nottaken_q <= nottaken_q + 16'd1;
        end
    end

    assign taken_cnt    = taken_q;
    assign nottaken_cnt = nottaken_q;
`else
    assign taken_cnt    = 16'd0;
    assign nottaken_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Scoreboard bench for pc_redirect_unit: per-cycle expected {pc, redirect, flush}
// are queued with each stimulus and popped after the clock edge.
module tb_pc_redirect_unit;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        br_valid;
    logic        bcres;
    logic [31:0] br_pc;
    logic [31:0] br_offset;
    logic        jump_valid;
    logic [31:0] jump_target;
    logic [31:0] pc;
    logic        redirect;
    logic        flush;
    logic [15:0] taken_cnt;
    logic [15:0] nottaken_cnt;

    pc_redirect_unit dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .br_valid    (br_valid),
        .bcres       (bcres),
        .br_pc       (br_pc),
        .br_offset   (br_offset),
        .jump_valid  (jump_valid),
        .jump_target (jump_target),
        .pc          (pc),
        .redirect    (redirect),
        .flush       (flush),
        .taken_cnt   (taken_cnt),
        .nottaken_cnt(nottaken_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic        stall;
        logic        bv;
        logic        bc;
        logic [31:0] bpc;
        logic [31:0] boff;
        logic        jv;
        logic [31:0] jt;
    } stim_t;

    typedef struct packed {
        logic [31:0] pc;
        logic        redirect;
        logic        flush;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    function automatic stim_t mk(logic s, logic bv, logic bc, logic [31:0] bpc,
                                 logic [31:0] boff, logic jv, logic [31:0] jt);
        return {s, bv, bc, bpc, boff, jv, jt};
    endfunction

    function automatic exp_t ex(logic [31:0] p, logic r, logic f);
        return {p, r, f};
    endfunction

    task automatic apply(input stim_t s);
        stall       = s.stall;
        br_valid    = s.bv;
        bcres       = s.bc;
        br_pc       = s.bpc;
        br_offset   = s.boff;
        jump_valid  = s.jv;
        jump_target = s.jt;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        stim_t st[$];
        exp_t  want[$];
        exp_t  got;
        rst = 1'b1;
        apply(mk(0, 0, 0, 0, 0, 0, 0));
        repeat (2) tick();
        got = {pc, redirect, flush};
        total++;
        if (got !== ex(32'h0, 0, 0)) begin
            bad++;
            $display("FAIL reset_state got pc=%h redirect=%b flush=%b want pc=00000000 redirect=0 flush=0",
                     pc, redirect, flush);
        end else $display("reset_state pc=%h redirect=%b flush=%b", pc, redirect, flush);
        total++;
        if ({taken_cnt, nottaken_cnt} !== 32'h0) begin
            bad++;
            $display("FAIL reset_counts got taken=%0d nottaken=%0d want 0 0", taken_cnt, nottaken_cnt);
        end else $display("reset_counts taken=%0d nottaken=%0d", taken_cnt, nottaken_cnt);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            st.push_back(mk(0, 0, 0, 0, 0, 0, 0));
            want.push_back(ex(32'(4 * (i + 1)), 0, 0));
        end
        foreach (st[i]) begin
            exp_t e;
            apply(st[i]);
            sb.push_back(want[i]);
            tick();
            e   = sb.pop_front();
            got = {pc, redirect, flush};
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL reset_seq[%0d] got pc=%h r=%b f=%b want pc=%h r=%b f=%b",
                         i, got.pc, got.redirect, got.flush, e.pc, e.redirect, e.flush);
            end else $display("reset_seq[%0d] pc=%h r=%b f=%b", i, got.pc, got.redirect, got.flush);
        end
    endtask

    task automatic test_branch_taken();
        stim_t st[$];
        exp_t  want[$];
        st.push_back(mk(0, 1, 1, 32'h100, 32'hFFFF_FFFC, 0, 0)); want.push_back(ex(32'hF4, 1, 1));
        st.push_back(mk(0, 0, 0, 0, 0, 0, 0));                   want.push_back(ex(32'hF8, 0, 1));
        st.push_back(mk(0, 0, 0, 0, 0, 0, 0));                   want.push_back(ex(32'hFC, 0, 0));
        st.push_back(mk(0, 0, 0, 0, 0, 0, 0));                   want.push_back(ex(32'h100, 0, 0));
        foreach (st[i]) begin
            exp_t e, got;
            apply(st[i]);
            sb.push_back(want[i]);
            tick();
            e   = sb.pop_front();
            got = {pc, redirect, flush};
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL branch_taken[%0d] got pc=%h r=%b f=%b want pc=%h r=%b f=%b",
                         i, got.pc, got.redirect, got.flush, e.pc, e.redirect, e.flush);
            end else $display("branch_taken[%0d] pc=%h r=%b f=%b", i, got.pc, got.redirect, got.flush);
        end
    endtask

    task automatic test_not_taken();
        stim_t st[$];
        exp_t  want[$];
        st.push_back(mk(0, 1, 0, 32'h500, 32'h8, 0, 0));  want.push_back(ex(32'h104, 0, 0));
        st.push_back(mk(0, 1, 0, 32'h600, 32'h40, 0, 0)); want.push_back(ex(32'h108, 0, 0));
        foreach (st[i]) begin
            exp_t e, got;
            apply(st[i]);
            sb.push_back(want[i]);
            tick();
            e   = sb.pop_front();
            got = {pc, redirect, flush};
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL not_taken[%0d] got pc=%h r=%b f=%b want pc=%h r=%b f=%b",
                         i, got.pc, got.redirect, got.flush, e.pc, e.redirect, e.flush);
            end else $display("not_taken[%0d] pc=%h r=%b f=%b", i, got.pc, got.redirect, got.flush);
        end
    endtask

    task automatic test_priority();
        stim_t st[$];
        exp_t  want[$];
        st.push_back(mk(0, 1, 1, 32'h1FC, 32'h0, 1, 32'h403)); want.push_back(ex(32'h200, 1, 1));
        st.push_back(mk(0, 0, 0, 0, 0, 1, 32'h400));           want.push_back(ex(32'h204, 0, 1));
        st.push_back(mk(0, 1, 1, 32'h1000, 32'h0, 0, 0));      want.push_back(ex(32'h208, 0, 0));
        foreach (st[i]) begin
            exp_t e, got;
            apply(st[i]);
            sb.push_back(want[i]);
            tick();
            e   = sb.pop_front();
            got = {pc, redirect, flush};
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL priority[%0d] got pc=%h r=%b f=%b want pc=%h r=%b f=%b",
                         i, got.pc, got.redirect, got.flush, e.pc, e.redirect, e.flush);
            end else $display("priority[%0d] pc=%h r=%b f=%b", i, got.pc, got.redirect, got.flush);
        end
    endtask

    task automatic test_jump();
        stim_t st[$];
        exp_t  want[$];
        st.push_back(mk(0, 0, 0, 0, 0, 1, 32'h403)); want.push_back(ex(32'h400, 1, 1));
        st.push_back(mk(0, 0, 0, 0, 0, 0, 0));       want.push_back(ex(32'h404, 0, 1));
        st.push_back(mk(0, 0, 0, 0, 0, 0, 0));       want.push_back(ex(32'h408, 0, 0));
        foreach (st[i]) begin
            exp_t e, got;
            apply(st[i]);
            sb.push_back(want[i]);
            tick();
            e   = sb.pop_front();
            got = {pc, redirect, flush};
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL jump[%0d] got pc=%h r=%b f=%b want pc=%h r=%b f=%b",
                         i, got.pc, got.redirect, got.flush, e.pc, e.redirect, e.flush);
            end else $display("jump[%0d] pc=%h r=%b f=%b", i, got.pc, got.redirect, got.flush);
        end
    endtask

    task automatic test_stall_flush();
        stim_t st[$];
        exp_t  want[$];
        st.push_back(mk(1, 1, 1, 32'h300, 32'h4, 0, 0)); want.push_back(ex(32'h314, 1, 1));
        for (int k = 0; k < 3; k++) begin
            st.push_back(mk(1, 0, 0, 0, 0, 0, 0));       want.push_back(ex(32'h314, 0, 1));
        end
        st.push_back(mk(0, 0, 0, 0, 0, 0, 0));           want.push_back(ex(32'h318, 0, 1));
        st.push_back(mk(0, 0, 0, 0, 0, 0, 0));           want.push_back(ex(32'h31C, 0, 0));
        st.push_back(mk(1, 0, 0, 0, 0, 0, 0));           want.push_back(ex(32'h31C, 0, 0));
        st.push_back(mk(0, 0, 0, 0, 0, 0, 0));           want.push_back(ex(32'h320, 0, 0));
        foreach (st[i]) begin
            exp_t e, got;
            apply(st[i]);
            sb.push_back(want[i]);
            tick();
            e   = sb.pop_front();
            got = {pc, redirect, flush};
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL stall_flush[%0d] got pc=%h r=%b f=%b want pc=%h r=%b f=%b",
                         i, got.pc, got.redirect, got.flush, e.pc, e.redirect, e.flush);
            end else $display("stall_flush[%0d] pc=%h r=%b f=%b", i, got.pc, got.redirect, got.flush);
        end
    endtask

    task automatic test_stats();
        logic [15:0] want_t, want_nt;
`ifdef BRANCH_STATS_EN
        want_t  = 16'd3;
        want_nt = 16'd2;
`else
        want_t  = 16'd0;
        want_nt = 16'd0;
`endif
        total++;
        if (taken_cnt !== want_t) begin
            bad++;
            $display("FAIL taken_cnt got %0d want %0d", taken_cnt, want_t);
        end else $display("taken_cnt %0d", taken_cnt);
        total++;
        if (nottaken_cnt !== want_nt) begin
            bad++;
            $display("FAIL nottaken_cnt got %0d want %0d", nottaken_cnt, want_nt);
        end else $display("nottaken_cnt %0d", nottaken_cnt);
    endtask

    task automatic test_wrap_reset();
        stim_t st[$];
        exp_t  want[$];
        exp_t  got;
        st.push_back(mk(0, 1, 1, 32'hFFFF_FFF8, 32'h1, 0, 0)); want.push_back(ex(32'h0, 1, 1));
        st.push_back(mk(0, 0, 0, 0, 0, 0, 0));                 want.push_back(ex(32'h4, 0, 1));
        foreach (st[i]) begin
            exp_t e;
            apply(st[i]);
            sb.push_back(want[i]);
            tick();
            e   = sb.pop_front();
            got = {pc, redirect, flush};
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL wrap[%0d] got pc=%h r=%b f=%b want pc=%h r=%b f=%b",
                         i, got.pc, got.redirect, got.flush, e.pc, e.redirect, e.flush);
            end else $display("wrap[%0d] pc=%h r=%b f=%b", i, got.pc, got.redirect, got.flush);
        end
        // Still mid-flush here: reset must take effect without waiting for an edge.
        rst = 1'b1;
        #1;
        got = {pc, redirect, flush};
        total++;
        if (got !== ex(32'h0, 0, 0)) begin
            bad++;
            $display("FAIL async_reset got pc=%h r=%b f=%b want pc=00000000 r=0 f=0",
                     got.pc, got.redirect, got.flush);
        end else $display("async_reset pc=%h r=%b f=%b", got.pc, got.redirect, got.flush);
        total++;
        if ({taken_cnt, nottaken_cnt} !== 32'h0) begin
            bad++;
            $display("FAIL async_reset_counts got taken=%0d nottaken=%0d want 0 0", taken_cnt, nottaken_cnt);
        end else $display("async_reset_counts taken=%0d nottaken=%0d", taken_cnt, nottaken_cnt);
        #2;
        rst = 1'b0;
        st.delete();
        want.delete();
        st.push_back(mk(0, 0, 0, 0, 0, 1, 32'h80)); want.push_back(ex(32'h80, 1, 1));
        st.push_back(mk(0, 0, 0, 0, 0, 0, 0));      want.push_back(ex(32'h84, 0, 1));
        st.push_back(mk(0, 0, 0, 0, 0, 0, 0));      want.push_back(ex(32'h88, 0, 0));
        foreach (st[i]) begin
            exp_t e;
            apply(st[i]);
            sb.push_back(want[i]);
            tick();
            e   = sb.pop_front();
            got = {pc, redirect, flush};
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL post_reset[%0d] got pc=%h r=%b f=%b want pc=%h r=%b f=%b",
                         i, got.pc, got.redirect, got.flush, e.pc, e.redirect, e.flush);
            end else $display("post_reset[%0d] pc=%h r=%b f=%b", i, got.pc, got.redirect, got.flush);
        end
    endtask

    initial begin
        test_reset();
        test_branch_taken();
        test_not_taken();
        test_priority();
        test_jump();
        test_stall_flush();
        test_stats();
        test_wrap_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
